// File: rtl/ahb_decoder_pkg.sv
// Shared definitions for the AHB-Lite N-port decoder and its default slave:
// HTRANS/HRESP encodings and the default-slave state type.
package ahb_decoder_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

endpackage

// File: rtl/ahblite_default_slave.sv
// Default slave: answers unmapped NONSEQ/SEQ with a two-cycle ERROR.
// Ports: HCLK, HRESET, HREADY, nomatch, HTRANS, HADDR in; ready, resp out;
// with DECODER_ERRLOG_EN also ERR_CLR in, ERR_VALID/ERR_ADDR/ERR_COUNT out.
module ahblite_default_slave
    import ahb_decoder_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HREADY,
    input  logic        nomatch,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HADDR,
    output logic        ready,
    output logic [1:0]  resp
`ifdef DECODER_ERRLOG_EN
    ,
    input  logic        ERR_CLR,
    output logic        ERR_VALID,
    output logic [31:0] ERR_ADDR,
    output logic [7:0]  ERR_COUNT
`endif
);

    ds_state_t state;
    logic      start;

    // Only active transfers (NONSEQ/SEQ) to an unmapped address error out.
    assign start = HREADY & nomatch & HTRANS[1];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= DS_IDLE;
            ready <= 1'b1;
            resp  <= HRESP_OKAY;
        end else begin
            case (state)
                DS_IDLE: begin
                    if (start) begin
                        state <= DS_ERR1;
                        ready <= 1'b0;
                        resp  <= HRESP_ERROR;
                    end
                end
                DS_ERR1: begin
                    state <= DS_ERR2;
                    ready <= 1'b1;
                    resp  <= HRESP_ERROR;
                end
                DS_ERR2: begin
                    if (start) begin
                        state <= DS_ERR1;
                        ready <= 1'b0;
                        resp  <= HRESP_ERROR;
                    end else begin
                        state <= DS_IDLE;
                        ready <= 1'b1;
                        resp  <= HRESP_OKAY;
                    end
                end
                default: begin
                    state <= DS_IDLE;
                    ready <= 1'b1;
                    resp  <= HRESP_OKAY;
                end
            endcase
        end
    end

`ifdef DECODER_ERRLOG_EN
    logic enter_err;
    logic unused_log;

    // ERR1 can only be entered from IDLE or ERR2.
    assign enter_err  = start & (state != DS_ERR1);
    assign unused_log = HTRANS[0];

    always_ff @(posedge HCLK) begin
        if (HRESET || ERR_CLR) begin
            ERR_VALID <= 1'b0;
            ERR_ADDR  <= '0;
            ERR_COUNT <= '0;
        end else if (enter_err) begin
            if (ERR_COUNT != 8'hFF)
                ERR_COUNT <= ERR_COUNT + 8'd1;
            if (!ERR_VALID) begin
                ERR_VALID <= 1'b1;
                ERR_ADDR  <= HADDR;
            end
        end
    end
`else
    logic unused_nolog;
    assign unused_nolog = ^{HADDR, HTRANS[0]};
`endif

endmodule

// File: rtl/ahblite_decoder_nport.sv
// AHB-Lite decoder for one master input stage driving NSLV output stages.
// Ports: HCLK, HRESET, HREADY, HADDR, HTRANS, per-slave ACTIVE_S, HREADYOUT_S,
// HRESP_S, HRDATA_S in; HSEL_S, ACTIVE, HREADYOUT, HRESP, HRDATA out.
// Optional macro DECODER_ERRLOG_EN adds ERR_CLR/ERR_VALID/ERR_ADDR/ERR_COUNT.
module ahblite_decoder_nport
    import ahb_decoder_pkg::*;
#(
    parameter int NSLV = 3,
    parameter logic [32*NSLV-1:0] ADDR_BASE =
        {32'h4003_0000, 32'h4001_0000, 32'h2000_0000},
    parameter logic [32*NSLV-1:0] ADDR_MASK =
        {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_F000}
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HREADY,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic [NSLV-1:0]   ACTIVE_S,
    input  logic [NSLV-1:0]   HREADYOUT_S,
    input  logic [2*NSLV-1:0] HRESP_S,
    input  logic [32*NSLV-1:0] HRDATA_S,
    output logic [NSLV-1:0]   HSEL_S,
    output logic              ACTIVE,
    output logic              HREADYOUT,
    output logic [1:0]        HRESP,
    output logic [31:0]       HRDATA
`ifdef DECODER_ERRLOG_EN
    ,
    input  logic              ERR_CLR,
    output logic              ERR_VALID,
    output logic [31:0]       ERR_ADDR,
    output logic [7:0]        ERR_COUNT
`endif
);

    logic [NSLV-1:0] hit;
    logic            nomatch;
    logic [NSLV:0]   sel_q;
    logic            ds_ready;
    logic [1:0]      ds_resp;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NSLV; i++)
            hit[i] = (HADDR & ADDR_MASK[32*i +: 32]) == ADDR_BASE[32*i +: 32];
    end

    // Walk from the top so the lowest matching index wins on overlap.
    always_comb begin
        HSEL_S = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (hit[i]) begin
                HSEL_S    = '0;
                HSEL_S[i] = 1'b1;
            end
        end
    end

    assign nomatch = ~|hit;
    assign ACTIVE  = nomatch | (|(ACTIVE_S & HSEL_S));

    // Data-phase select; bit NSLV is the default slave.
    always_ff @(posedge HCLK) begin
        if (HRESET)
            sel_q <= '0;
        else if (HREADY)
            sel_q <= {nomatch, HSEL_S};
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_q[i]) begin
                HREADYOUT = HREADYOUT_S[i];
                HRESP     = HRESP_S[2*i +: 2];
                HRDATA    = HRDATA_S[32*i +: 32];
            end
        end
        if (sel_q[NSLV]) begin
            HREADYOUT = ds_ready;
            HRESP     = ds_resp;
        end
    end

    ahblite_default_slave u_def (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HREADY    (HREADY),
        .nomatch   (nomatch),
        .HTRANS    (HTRANS),
        .HADDR     (HADDR),
        .ready     (ds_ready),
        .resp      (ds_resp)
`ifdef DECODER_ERRLOG_EN
        ,
        .ERR_CLR   (ERR_CLR),
        .ERR_VALID (ERR_VALID),
        .ERR_ADDR  (ERR_ADDR),
        .ERR_COUNT (ERR_COUNT)
`endif
    );

endmodule

// File: tb/tb_ahblite_decoder_nport.sv
// Directed testbench for ahblite_decoder_nport (default build and,
// when DECODER_ERRLOG_EN is defined, the error log).
module tb_ahblite_decoder_nport;

    logic        clk = 1'b0;
    logic        rst;
    logic        hready;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  active_s;
    logic [2:0]  hreadyout_s;
    logic [5:0]  hresp_s;
    logic [95:0] hrdata_s;
    logic [2:0]  hsel_s;
    logic        active;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic        err_clr;
    logic        err_valid;
    logic [31:0] err_addr;
    logic [7:0]  err_count;

    logic [1:0]  ovl_hsel;
    logic        unused_ovl_active;
    logic        unused_ovl_ready;
    logic [1:0]  unused_ovl_resp;
    logic [31:0] unused_ovl_rdata;
    logic        unused_ovl_valid;
    logic [31:0] unused_ovl_addr;
    logic [7:0]  unused_ovl_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Single master: bus HREADY is the muxed HREADYOUT.
    assign hready = hreadyout;

    ahblite_decoder_nport dut (
        .HCLK        (clk),
        .HRESET      (rst),
        .HREADY      (hready),
        .HADDR       (haddr),
        .HTRANS      (htrans),
        .ACTIVE_S    (active_s),
        .HREADYOUT_S (hreadyout_s),
        .HRESP_S     (hresp_s),
        .HRDATA_S    (hrdata_s),
        .HSEL_S      (hsel_s),
        .ACTIVE      (active),
        .HREADYOUT   (hreadyout),
        .HRESP       (hresp),
        .HRDATA      (hrdata)
`ifdef DECODER_ERRLOG_EN
        ,
        .ERR_CLR     (err_clr),
        .ERR_VALID   (err_valid),
        .ERR_ADDR    (err_addr),
        .ERR_COUNT   (err_count)
`endif
    );

    ahblite_decoder_nport #(
        .NSLV      (2),
        .ADDR_BASE ({32'h4001_0000, 32'h4000_0000}),
        .ADDR_MASK ({32'hFFFF_0000, 32'hFFF0_0000})
    ) ovl (
        .HCLK        (clk),
        .HRESET      (rst),
        .HREADY      (1'b1),
        .HADDR       (haddr),
        .HTRANS      (htrans),
        .ACTIVE_S    (2'b11),
        .HREADYOUT_S (2'b11),
        .HRESP_S     (4'b0000),
        .HRDATA_S    (64'd0),
        .HSEL_S      (ovl_hsel),
        .ACTIVE      (unused_ovl_active),
        .HREADYOUT   (unused_ovl_ready),
        .HRESP       (unused_ovl_resp),
        .HRDATA      (unused_ovl_rdata)
`ifdef DECODER_ERRLOG_EN
        ,
        .ERR_CLR     (err_clr),
        .ERR_VALID   (unused_ovl_valid),
        .ERR_ADDR    (unused_ovl_addr),
        .ERR_COUNT   (unused_ovl_count)
`endif
    );

`ifndef DECODER_ERRLOG_EN
    assign err_valid        = 1'b0;
    assign err_addr         = '0;
    assign err_count        = '0;
    assign unused_ovl_valid = 1'b0;
    assign unused_ovl_addr  = '0;
    assign unused_ovl_count = '0;
`endif

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input string tag, input logic rdy, input logic [1:0] rsp);
        @(negedge clk);
        check({tag, "_rdy"}, {31'd0, hreadyout}, {31'd0, rdy});
        check({tag, "_rsp"}, {30'd0, hresp}, {30'd0, rsp});
    endtask

    logic [31:0] dec_addr [7];
    logic [2:0]  dec_sel  [7];
    logic        dec_act  [7];

    initial begin
        dec_addr = '{32'h2000_0000, 32'h2000_0FFC, 32'h2000_1000,
                     32'h4001_0000, 32'h4001_FFFF, 32'h4003_1234,
                     32'h4002_0000};
        dec_sel  = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b100, 3'b000};
        dec_act  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        rst         = 1'b1;
        haddr       = '0;
        htrans      = 2'b00;
        active_s    = 3'b010;
        hreadyout_s = 3'b111;
        hresp_s     = '0;
        hrdata_s    = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF};
        err_clr     = 1'b0;

        tick();
        tick();
        @(negedge clk);
        check("rst_hsel", {29'd0, hsel_s}, 32'd0);
        check("rst_rdy", {31'd0, hreadyout}, 32'd1);
        check("rst_rsp", {30'd0, hresp}, 32'd0);
        check("rst_rdata", hrdata, 32'd0);
`ifdef DECODER_ERRLOG_EN
        check("rst_cnt", {24'd0, err_count}, 32'd0);
`endif
        tick();
        rst = 1'b0;

        // Combinational decode, including region edges and HTRANS=IDLE.
        for (int i = 0; i < 7; i++) begin
            haddr = dec_addr[i];
            #1;
            check("dec_hsel", {29'd0, hsel_s}, {29'd0, dec_sel[i]});
            check("dec_act", {31'd0, active}, {31'd0, dec_act[i]});
        end
        haddr = '0;
        tick();

        // Read from slave 0 with one wait state.
        haddr       = 32'h2000_0010;
        htrans      = 2'b10;
        hreadyout_s = 3'b110;
        @(negedge clk);
        check("rd_hsel", {29'd0, hsel_s}, 32'd1);
        tick();
        // Address offered during the wait must be ignored.
        haddr = 32'h5000_0000;
        bus("rd_wait", 1'b0, 2'b00);
        tick();
        hreadyout_s = 3'b111;
        htrans      = 2'b00;
        haddr       = '0;
        bus("rd_done", 1'b1, 2'b00);
        check("rd_data", hrdata, 32'hDEAD_BEEF);
        tick();
        bus("idle_unmap", 1'b1, 2'b00);
        check("idle_rdata", hrdata, 32'd0);
        tick();

        // Single unmapped NONSEQ.
        haddr  = 32'h5000_0000;
        htrans = 2'b10;
        @(negedge clk);
        check("um_hsel", {29'd0, hsel_s}, 32'd0);
        check("um_act", {31'd0, active}, 32'd1);
        tick();
        htrans = 2'b00;
        haddr  = '0;
        bus("um_err1", 1'b0, 2'b01);
        check("um_rdata", hrdata, 32'd0);
        tick();
        bus("um_err2", 1'b1, 2'b01);
        tick();
        bus("um_idle", 1'b1, 2'b00);
`ifdef DECODER_ERRLOG_EN
        check("um_valid", {31'd0, err_valid}, 32'd1);
        check("um_addr", err_addr, 32'h5000_0000);
        check("um_cnt", {24'd0, err_count}, 32'd1);
`endif
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Back-to-back unmapped transfers.
        haddr  = 32'h6000_0000;
        htrans = 2'b10;
        tick();
        haddr = 32'h6000_0004;
        bus("b2b_err1a", 1'b0, 2'b01);
        tick();
        bus("b2b_err2a", 1'b1, 2'b01);
        tick();
        htrans = 2'b00;
        haddr  = '0;
        bus("b2b_err1b", 1'b0, 2'b01);
        tick();
        bus("b2b_err2b", 1'b1, 2'b01);
        tick();
        bus("b2b_idle", 1'b1, 2'b00);
`ifdef DECODER_ERRLOG_EN
        check("b2b_cnt", {24'd0, err_count}, 32'd2);
        check("b2b_addr", err_addr, 32'h6000_0000);
`endif
        tick();

        // IDLE and BUSY to unmapped: zero-wait OKAY.
        haddr  = 32'h5000_0000;
        htrans = 2'b00;
        tick();
        htrans = 2'b01;
        bus("idle_okay", 1'b1, 2'b00);
        tick();
        htrans = 2'b00;
        haddr  = '0;
        bus("busy_okay", 1'b1, 2'b00);
`ifdef DECODER_ERRLOG_EN
        check("idle_cnt", {24'd0, err_count}, 32'd2);
`endif
        tick();

        // 300 back-to-back errors.
        haddr  = 32'h7000_0000;
        htrans = 2'b10;
        repeat (600) tick();
        bus("sat_err2", 1'b1, 2'b01);
        tick();
        htrans = 2'b00;
        haddr  = '0;
        tick();
`ifdef DECODER_ERRLOG_EN
        @(negedge clk);
        check("sat_cnt", {24'd0, err_count}, 32'd255);
        tick();
`endif
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
`ifdef DECODER_ERRLOG_EN
        @(negedge clk);
        check("clr_cnt", {24'd0, err_count}, 32'd0);
        check("clr_valid", {31'd0, err_valid}, 32'd0);
        check("clr_addr", err_addr, 32'd0);
        tick();
`endif

        // Overlapping regions: lowest index wins.
        haddr = 32'h4001_0000;
        #1;
        check("ovl_hsel", {30'd0, ovl_hsel}, 32'd1);
        haddr = 32'h4000_0000;
        #1;
        check("ovl_hsel0", {30'd0, ovl_hsel}, 32'd1);
        haddr = 32'h4011_0000;
        #1;
        check("ovl_none", {30'd0, ovl_hsel}, 32'd0);
        haddr = '0;
        tick();

        // Reset asserted while in ERR1.
        haddr  = 32'h5000_0000;
        htrans = 2'b10;
        tick();
        htrans = 2'b00;
        haddr  = '0;
        rst    = 1'b1;
        bus("rst_err1", 1'b0, 2'b01);
        tick();
        bus("rst_after", 1'b1, 2'b00);
        check("rst_after_rd", hrdata, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
